// File: rtl/exp_2_sched.sv
// exp_2_sched
// Sequencer for one softmax pass through the exp_2 datapath.  On start it
// reads number_of_data shifted inputs from the input buffer and streams them
// back-to-back into the exp unit.  It writes each exp result into the output
// buffer at consecutive addresses and accumulates their sum, which the divide
// stage uses as the denominator.  A one-cycle done pulse marks the end of the
// pass.  If the exp unit stops returning results, a drain watchdog ends the
// pass early, delivers the partial sum and raises a sticky error flag.
//
// Ports:
//   clock_i, reset_i         clock (rising edge), async active-high reset
//   start_i                  begin a pass (sampled only while idle)
//   busy_o, done_o, err_o    pass in progress / completion pulse / drain timeout
//   rd_en_o, rd_addr_o       input buffer read strobe and address
//   rd_data_i                input buffer data, valid the cycle after rd_en_o
//   exp_data_o, exp_data_valid_o      operand stream to the exp unit
//   exp_result_i, exp_result_valid_i  result stream from the exp unit
//   wr_en_o, wr_addr_o, wr_data_o     output buffer write port
//   sum_o                    running sum of results, final while done_o is high
module exp_2_sched #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int addr_size      = 4,
  parameter int exp_latency    = 2
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic                           rd_en_o,
  output logic [addr_size-1:0]           rd_addr_o,
  input  logic [data_size-1:0]           rd_data_i,
  output logic [data_size-1:0]           exp_data_o,
  output logic                           exp_data_valid_o,
  input  logic [data_size-1:0]           exp_result_i,
  input  logic                           exp_result_valid_i,
  output logic                           wr_en_o,
  output logic [addr_size-1:0]           wr_addr_o,
  output logic [data_size-1:0]           wr_data_o,
  output logic [data_size+addr_size-1:0] sum_o
);

  // One extra bit so the write counter can hold the value N itself.
  localparam int cnt_w    = addr_size + 1;
  localparam int sum_w    = data_size + addr_size;
  localparam int wd_limit = 4 * exp_latency + 4;
  localparam int wd_w     = $clog2(wd_limit + 1);

  localparam logic [cnt_w-1:0] last_rd  = cnt_w'(number_of_data - 1);
  localparam logic [cnt_w-1:0] n_cnt    = cnt_w'(number_of_data);
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);
  localparam logic [wd_w-1:0]  wd_last  = wd_w'(wd_limit - 1);
  localparam logic [wd_w-1:0]  wd_one   = wd_w'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [cnt_w-1:0] rd_cnt_r;
  logic [cnt_w-1:0] wr_cnt_r;
  logic [wd_w-1:0]  wd_cnt_r;
  logic             rd_valid_r;

  logic             start_acc_s;
  logic             accept_s;
  logic             wd_expire_s;

  logic                 busy_s;
  logic                 done_s;
  logic                 err_s;
  logic                 rd_en_s;
  logic [addr_size-1:0] rd_addr_s;
  logic                 wr_en_s;
  logic [addr_size-1:0] wr_addr_s;
  logic [data_size-1:0] wr_data_s;
  logic [sum_w-1:0]     sum_s;
  logic [data_size-1:0] exp_data_s;

  // A start only counts while idle; results only count while a pass is
  // active and fewer than N have been written.
  assign start_acc_s = (state_r == IDLE) && start_i;
  assign accept_s    = exp_result_valid_i
                       && ((state_r == ISSUE) || (state_r == DRAIN))
                       && (wr_cnt_r < n_cnt);
  // Fires on the last of wd_limit consecutive result-less drain cycles.
  assign wd_expire_s = (state_r == DRAIN) && !exp_result_valid_i
                       && (wd_cnt_r == wd_last);

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (rd_cnt_r == last_rd) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if ((wr_cnt_r == n_cnt) || wd_expire_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output logic: next values of every registered output.  busy/done look at
  // the next state so done rises and busy falls on the edge entering DONE.
  always_comb begin
    busy_s     = (state_s == ISSUE) || (state_s == DRAIN);
    done_s     = (state_s == DONE);
    rd_en_s    = 1'b0;
    rd_addr_s  = {addr_size{1'b0}};
    wr_en_s    = 1'b0;
    wr_addr_s  = wr_addr_o;
    wr_data_s  = wr_data_o;
    err_s      = err_o;
    sum_s      = sum_o;
    exp_data_s = exp_data_o;

    if (state_r == ISSUE) begin
      rd_en_s   = 1'b1;
      rd_addr_s = rd_cnt_r[addr_size-1:0];
    end else begin
      rd_en_s   = 1'b0;
    end

    if (start_acc_s) begin
      err_s = 1'b0;
      sum_s = {sum_w{1'b0}};
    end else if (accept_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = wr_cnt_r[addr_size-1:0];
      wr_data_s = exp_result_i;
      sum_s     = sum_o + {{addr_size{1'b0}}, exp_result_i};
    end else if (wd_expire_s) begin
      err_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end

    // Read data arrives one cycle after the strobe; forward it with its valid.
    if (rd_valid_r) begin
      exp_data_s = rd_data_i;
    end else begin
      exp_data_s = exp_data_o;
    end
  end

  // Output registers and the read-data valid pipeline.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      rd_en_o          <= 1'b0;
      rd_addr_o        <= {addr_size{1'b0}};
      rd_valid_r       <= 1'b0;
      exp_data_o       <= {data_size{1'b0}};
      exp_data_valid_o <= 1'b0;
      wr_en_o          <= 1'b0;
      wr_addr_o        <= {addr_size{1'b0}};
      wr_data_o        <= {data_size{1'b0}};
      sum_o            <= {sum_w{1'b0}};
    end else begin
      busy_o           <= busy_s;
      done_o           <= done_s;
      err_o            <= err_s;
      rd_en_o          <= rd_en_s;
      rd_addr_o        <= rd_addr_s;
      rd_valid_r       <= rd_en_o;
      exp_data_o       <= exp_data_s;
      exp_data_valid_o <= rd_valid_r;
      wr_en_o          <= wr_en_s;
      wr_addr_o        <= wr_addr_s;
      wr_data_o        <= wr_data_s;
      sum_o            <= sum_s;
    end
  end

  // Read counter, write counter and drain watchdog counter.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_cnt_r <= {cnt_w{1'b0}};
      wr_cnt_r <= {cnt_w{1'b0}};
      wd_cnt_r <= {wd_w{1'b0}};
    end else begin
      if (start_acc_s) begin
        rd_cnt_r <= {cnt_w{1'b0}};
      end else if (state_r == ISSUE) begin
        rd_cnt_r <= rd_cnt_r + cnt_one;
      end else begin
        rd_cnt_r <= rd_cnt_r;
      end

      if (start_acc_s) begin
        wr_cnt_r <= {cnt_w{1'b0}};
      end else if (accept_s) begin
        wr_cnt_r <= wr_cnt_r + cnt_one;
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end

      // Counts consecutive result-less cycles, only while draining.
      if ((state_r == DRAIN) && !exp_result_valid_i) begin
        if (wd_cnt_r != wd_last) begin
          wd_cnt_r <= wd_cnt_r + wd_one;
        end else begin
          wd_cnt_r <= wd_cnt_r;
        end
      end else begin
        wd_cnt_r <= {wd_w{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_exp_2_sched.sv
// Testbench for exp_2_sched: two instances (N=10 and N=1), each with a
// behavioural input buffer and a latency-2 exp stub.  Expected writes are
// queued before a pass starts and popped as the DUT writes.
module tb_exp_2_sched;

  localparam int N0 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int errors = 0;

  // ---------------- DUT 0 (N=10) ----------------
  logic        start0, busy0, done0, err0, rd_en0, exp_valid0, res_valid0, wr_en0;
  logic [3:0]  rd_addr0, wr_addr0;
  logic [31:0] rd_data0 = 32'd0, exp_data0, res0, wr_data0;
  logic [35:0] sum0;

  exp_2_sched #(.data_size(32), .number_of_data(N0), .addr_size(4), .exp_latency(2)) dut0 (
    .clock_i(clk), .reset_i(rst), .start_i(start0), .busy_o(busy0), .done_o(done0),
    .err_o(err0), .rd_en_o(rd_en0), .rd_addr_o(rd_addr0), .rd_data_i(rd_data0),
    .exp_data_o(exp_data0), .exp_data_valid_o(exp_valid0), .exp_result_i(res0),
    .exp_result_valid_i(res_valid0), .wr_en_o(wr_en0), .wr_addr_o(wr_addr0),
    .wr_data_o(wr_data0), .sum_o(sum0));

  // Input buffer holds its own address (0..9).
  always @(posedge clk) if (rd_en0) rd_data0 <= 32'(rd_addr0);

  // Exp stub: mode 0 = input+1, mode 1 = all ones, mode 2 = input+1 but
  // results above 7 are dropped (only the first seven come back).
  logic [1:0]  mode;
  logic        inject0;
  logic        s1_v0 = 1'b0, s2_v0 = 1'b0;
  logic [31:0] s1_d0 = 32'd0, s2_d0 = 32'd0;
  always @(posedge clk) begin
    s1_v0 <= exp_valid0;
    s1_d0 <= (mode == 2'd1) ? 32'hFFFF_FFFF : exp_data0 + 32'd1;
    s2_v0 <= s1_v0 && !((mode == 2'd2) && (s1_d0 > 32'd7));
    s2_d0 <= s1_d0;
  end
  assign res_valid0 = s2_v0 | inject0;
  assign res0       = s2_d0;

  // ---------------- DUT 1 (N=1) ----------------
  logic        start1, busy1, done1, err1, rd_en1, exp_valid1, wr_en1;
  logic [3:0]  rd_addr1, wr_addr1;
  logic [31:0] rd_data1 = 32'd0, exp_data1, wr_data1;
  logic [35:0] sum1;
  logic        s1_v1 = 1'b0, s2_v1 = 1'b0;
  logic [31:0] s1_d1 = 32'd0, s2_d1 = 32'd0;

  exp_2_sched #(.data_size(32), .number_of_data(1), .addr_size(4), .exp_latency(2)) dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .err_o(err1), .rd_en_o(rd_en1), .rd_addr_o(rd_addr1), .rd_data_i(rd_data1),
    .exp_data_o(exp_data1), .exp_data_valid_o(exp_valid1), .exp_result_i(s2_d1),
    .exp_result_valid_i(s2_v1), .wr_en_o(wr_en1), .wr_addr_o(wr_addr1),
    .wr_data_o(wr_data1), .sum_o(sum1));

  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= 32'd5;
    s1_v1 <= exp_valid1;
    s1_d1 <= exp_data1 + 32'd1;
    s2_v1 <= s1_v1;
    s2_d1 <= s1_d1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [3:0] addr; logic [31:0] data;} wr_t;
  wr_t q0[$];
  wr_t q1[$];
  wr_t e0, e1;
  int  wr_seen0 = 0;

  // Scoreboard monitors: every write must match the head of its queue.
  always @(negedge clk) begin
    if (wr_en0) begin
      wr_seen0 = wr_seen0 + 1;
      if (q0.size() == 0) begin
        chk("wr0_unexpected", 64'd1, 64'd0);
      end else begin
        e0 = q0.pop_front();
        chk("wr0_addr", 64'(wr_addr0), 64'(e0.addr));
        chk("wr0_data", 64'(wr_data0), 64'(e0.data));
      end
    end
    if (wr_en1) begin
      if (q1.size() == 0) begin
        chk("wr1_unexpected", 64'd1, 64'd0);
      end else begin
        e1 = q1.pop_front();
        chk("wr1_addr", 64'(wr_addr1), 64'(e1.addr));
        chk("wr1_data", 64'(wr_data1), 64'(e1.data));
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [35:0] exp_sum;
    logic        exp_err;
    int          exp_writes;
    int          exp_done_off;
  } vec_t;
  vec_t tbl[3];

  task automatic push_pass(input logic [1:0] m, input int nwr);
    wr_t w;
    for (int i = 0; i < nwr; i++) begin
      w.addr = 4'(i);
      w.data = (m == 2'd1) ? 32'hFFFF_FFFF : 32'(i + 1);
      q0.push_back(w);
    end
  endtask

  // One pass on DUT 0 with per-cycle timing checks relative to the start edge.
  task automatic run_pass(input vec_t v);
    int dcnt, doff, base;
    mode = v.mode;
    push_pass(v.mode, v.exp_writes);
    base = wr_seen0;
    dcnt = 0;
    doff = -1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int off = 0; off < 40; off++) begin
      @(negedge clk);
      #1;
      if (off == 0) start0 = 1'b0;
      if (off >= 1 && off <= N0 + 2) begin
        chk("rd_en", 64'(rd_en0), 64'(off <= N0));
        if (off <= N0) chk("rd_addr", 64'(rd_addr0), 64'(off - 1));
        chk("exp_valid", 64'(exp_valid0), 64'(off >= 3));
      end
      if (off == 1) begin
        chk("busy", 64'(busy0), 64'd1);
        chk("err_cleared", 64'(err0), 64'd0);
      end
      if (done0) begin
        dcnt++;
        if (doff < 0) doff = off;
        chk("busy_at_done", 64'(busy0), 64'd0);
        chk("sum_at_done", 64'(sum0), 64'(v.exp_sum));
      end
    end
    chk("done_count", 64'(dcnt), 64'd1);
    chk("done_offset", 64'(doff), 64'(v.exp_done_off));
    chk("sum", 64'(sum0), 64'(v.exp_sum));
    chk("err", 64'(err0), 64'(v.exp_err));
    chk("writes", 64'(wr_seen0 - base), 64'(v.exp_writes));
    chk("queue_empty", 64'(q0.size()), 64'd0);
  endtask

  initial begin
    int dcnt, d1, d2, w, base, rdc, doff;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; inject0 = 1'b0; mode = 2'd0;
    tbl[0] = '{2'd0, 36'd55,           1'b0, 10, 16};
    tbl[1] = '{2'd1, 36'h9_FFFF_FFF6,  1'b0, 10, 16};
    tbl[2] = '{2'd2, 36'd28,           1'b1, 7,  24};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_rd_en", 64'(rd_en0), 64'd0);
    chk("rst_wr_en", 64'(wr_en0), 64'd0);
    chk("rst_sum", 64'(sum0), 64'd0);
    chk("rst_exp_valid", 64'(exp_valid0), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 3; t++) run_pass(tbl[t]);

    // Spurious result while idle: no write, sum and err unchanged.
    @(negedge clk); inject0 = 1'b1;
    @(negedge clk); inject0 = 1'b0;
    chk("spur_wr", 64'(wr_en0), 64'd0);
    repeat (2) @(negedge clk);
    chk("spur_sum", 64'(sum0), 64'd28);
    chk("spur_err", 64'(err0), 64'd1);

    // start held for 30 cycles: exactly two back-to-back passes.
    mode = 2'd0;
    push_pass(2'd0, 10);
    push_pass(2'd0, 10);
    dcnt = 0; d1 = -1; d2 = -1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    for (int off = 0; off < 60; off++) begin
      @(negedge clk);
      if (off == 1) chk("held_err_cleared", 64'(err0), 64'd0);
      if (done0) begin
        dcnt++;
        if (d1 < 0) d1 = off; else if (d2 < 0) d2 = off;
      end
      if (off == 29) start0 = 1'b0;
    end
    chk("held_done_count", 64'(dcnt), 64'd2);
    chk("held_done1", 64'(d1), 64'd16);
    chk("held_done2", 64'(d2), 64'd34);
    chk("held_sum", 64'(sum0), 64'd55);
    chk("held_queue", 64'(q0.size()), 64'd0);

    // Asynchronous reset in mid-pass after four writes.
    push_pass(2'd0, 10);
    base = wr_seen0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    w = 0;
    #1;
    while ((wr_seen0 - base) < 4 && w < 40) begin
      @(negedge clk); #1;
      w++;
    end
    chk("rst_wait_bound", 64'(w < 40), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy0), 64'd0);
    chk("arst_done", 64'(done0), 64'd0);
    chk("arst_rd_en", 64'(rd_en0), 64'd0);
    chk("arst_wr_en", 64'(wr_en0), 64'd0);
    chk("arst_wr_addr", 64'(wr_addr0), 64'd0);
    chk("arst_wr_data", 64'(wr_data0), 64'd0);
    chk("arst_sum", 64'(sum0), 64'd0);
    chk("arst_exp", 64'({exp_valid0, exp_data0}), 64'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int off = 0; off < 20; off++) begin
      @(negedge clk);
      if (done0) dcnt++;
    end
    chk("no_done_after_rst", 64'(dcnt), 64'd0);
    run_pass(tbl[0]);

    // N=1 instance: one read, one write of 6, done at offset 7.
    q1.push_back({4'd0, 32'd6});
    rdc = 0; doff = -1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    for (int off = 0; off < 20; off++) begin
      @(negedge clk);
      if (off == 0) start1 = 1'b0;
      if (rd_en1) begin
        rdc++;
        chk("n1_rd_addr", 64'(rd_addr1), 64'd0);
      end
      if (done1 && doff < 0) doff = off;
    end
    chk("n1_reads", 64'(rdc), 64'd1);
    chk("n1_done_offset", 64'(doff), 64'd7);
    chk("n1_sum", 64'(sum1), 64'd6);
    chk("n1_err", 64'(err1), 64'd0);
    chk("n1_queue", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
